// File: rtl/odd_fwd_scoreboard.sv
// odd_fwd_scoreboard: result staging, forwarding and RAW-hazard scoreboard
// for the odd pipe. Every register-writing issue becomes an age-tagged entry
// that shifts one stage per cycle. Each unit's result is captured into the
// stage equal to that unit's latency. The final stage (DEPTH) drives the
// register-file write port.
// Optional feature macro: FWD_MUX_EN. When it is defined, operands are
// forwarded from the staging stages. When it is undefined, any in-flight
// match stalls until write-back has completed.
module odd_fwd_scoreboard #(
  parameter int DEPTH   = 7,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7,
  parameter int NUM_SRC = 6,
  parameter int LAT_P   = 4,
  parameter int LAT_LS  = 6,
  parameter int LAT_BR  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [1:0]                issue_unit,
  input  logic [ADDR_W-1:0]         issue_rt_addr,
  input  logic                      issue_reg_write,
  input  logic [2:0]                unit_valid,
  input  logic [3*DATA_W-1:0]       unit_data,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_stall,
  output logic [NUM_SRC-1:0]        src_fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0] src_fwd_data,
  output logic                      wb_valid,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      err_orphan,
  output logic                      err_missing
);

  // Latency of a (normalised) unit code: 0 = P, 1 = LS, 2 = BR.
  function automatic int lat_of(input logic [1:0] u);
    case (u)
      2'd1:    lat_of = LAT_LS;
      2'd2:    lat_of = LAT_BR;
      default: lat_of = LAT_P;
    endcase
  endfunction

  // Registered entries at ages 1..DEPTH.
  logic              vld_q  [1:DEPTH];
  logic              vld_d  [1:DEPTH];
  logic [ADDR_W-1:0] addr_q [1:DEPTH];
  logic [ADDR_W-1:0] addr_d [1:DEPTH];
  logic [1:0]        unit_q [1:DEPTH];
  logic [1:0]        unit_d [1:DEPTH];
  logic [DATA_W-1:0] data_q [1:DEPTH];
  logic [DATA_W-1:0] data_d [1:DEPTH];
  logic              err_orphan_q, err_orphan_d;
  logic              err_missing_q, err_missing_d;

  // Uniform view of ages 0..DEPTH; age 0 is the issue of this cycle.
  logic              age_vld  [0:DEPTH];
  logic [ADDR_W-1:0] age_addr [0:DEPTH];
  logic [1:0]        age_unit [0:DEPTH];
  logic [DATA_W-1:0] age_data [0:DEPTH];

  logic [2:0]        cap_hit;
  logic              missing_set;
  logic              found;
`ifdef FWD_MUX_EN
  logic              f_pend;
  logic [DATA_W-1:0] f_data;
`endif

  // Assemble the age view. Issue code 3 is an alias for the permute unit.
  always_comb begin
    age_vld[0]  = issue_valid & issue_reg_write;
    age_addr[0] = issue_rt_addr;
    age_unit[0] = (issue_unit == 2'd3) ? 2'd0 : issue_unit;
    age_data[0] = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      age_vld[k]  = vld_q[k];
      age_addr[k] = addr_q[k];
      age_unit[k] = unit_q[k];
      age_data[k] = data_q[k];
    end
  end

  // Shift entries one age and capture unit results at each unit's latency stage.
  always_comb begin
    cap_hit     = '0;
    missing_set = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      vld_d[k+1]  = age_vld[k];
      addr_d[k+1] = age_addr[k];
      unit_d[k+1] = age_unit[k];
      data_d[k+1] = age_data[k];
      if (age_vld[k] && (lat_of(age_unit[k]) == k + 1)) begin
        cap_hit[age_unit[k]] = 1'b1;
        if (unit_valid[age_unit[k]]) begin
          data_d[k+1] = unit_data[age_unit[k]*DATA_W +: DATA_W];
        end else begin
          // No result at the capture point: drop the entry so it never writes back.
          vld_d[k+1]  = 1'b0;
          missing_set = 1'b1;
        end
      end
    end
    err_orphan_d  = err_orphan_q | (|(unit_valid & ~cap_hit));
    err_missing_d = err_missing_q | missing_set;
  end

  // ---- stage boundary: control state (entry valids, sticky error flags) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) vld_q[k] <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      err_orphan_q  <= err_orphan_d;
      err_missing_q <= err_missing_d;
    end
  end

  // ---- stage boundary: payload, always qualified by vld_q so it needs no reset ----
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    unit_q <= unit_d;
    data_q <= data_d;
  end

  // Per-operand lookup: the youngest matching age decides stall, forward or miss.
  always_comb begin
    src_stall    = '0;
    src_fwd_hit  = '0;
    src_fwd_data = '0;
    found        = 1'b0;
`ifdef FWD_MUX_EN
    f_pend       = 1'b0;
    f_data       = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
`ifdef FWD_MUX_EN
      f_pend = 1'b0;
      f_data = '0;
`endif
      // Scan oldest to youngest so that the youngest match is the one kept.
      for (int k = DEPTH; k >= 0; k--) begin
        if (age_vld[k] && (age_addr[k] == src_addr[i*ADDR_W +: ADDR_W])) begin
          found = 1'b1;
`ifdef FWD_MUX_EN
          f_pend = (k < lat_of(age_unit[k]));
          f_data = age_data[k];
`endif
        end
      end
      if (src_valid[i] && found) begin
`ifdef FWD_MUX_EN
        if (f_pend) begin
          src_stall[i] = 1'b1;
        end else begin
          src_fwd_hit[i]                    = 1'b1;
          src_fwd_data[i*DATA_W +: DATA_W] = f_data;
        end
`else
        src_stall[i] = 1'b1;
`endif
      end
    end
    if (reset) begin
      src_stall    = '1;
      src_fwd_hit  = '0;
      src_fwd_data = '0;
    end
  end

  assign wb_valid    = vld_q[DEPTH];
  assign wb_addr     = vld_q[DEPTH] ? addr_q[DEPTH] : '0;
  assign wb_data     = vld_q[DEPTH] ? data_q[DEPTH] : '0;
  assign err_orphan  = err_orphan_q;
  assign err_missing = err_missing_q;

endmodule

// File: tb/tb_odd_fwd_scoreboard.sv
// Testbench for odd_fwd_scoreboard: directed scenarios, a queue-based
// reference model checked every cycle, and literal expectations per scenario.
module tb_odd_fwd_scoreboard;
  localparam int DEPTH   = 7;
  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 7;
  localparam int NUM_SRC = 6;
  localparam int LAT_P   = 4;
  localparam int LAT_LS  = 6;
  localparam int LAT_BR  = 1;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      issue_valid = 1'b0;
  logic [1:0]                issue_unit = '0;
  logic [ADDR_W-1:0]         issue_rt_addr = '0;
  logic                      issue_reg_write = 1'b0;
  logic [2:0]                unit_valid = '0;
  logic [3*DATA_W-1:0]       unit_data = '0;
  logic [NUM_SRC*ADDR_W-1:0] src_addr = '0;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC-1:0]        src_stall;
  logic [NUM_SRC-1:0]        src_fwd_hit;
  logic [NUM_SRC*DATA_W-1:0] src_fwd_data;
  logic                      wb_valid;
  logic [ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic                      err_orphan;
  logic                      err_missing;

  always #5 clk = ~clk;

  odd_fwd_scoreboard #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
    .LAT_P(LAT_P), .LAT_LS(LAT_LS), .LAT_BR(LAT_BR)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_rt_addr(issue_rt_addr), .issue_reg_write(issue_reg_write),
    .unit_valid(unit_valid), .unit_data(unit_data),
    .src_addr(src_addr), .src_valid(src_valid),
    .src_stall(src_stall), .src_fwd_hit(src_fwd_hit), .src_fwd_data(src_fwd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .err_orphan(err_orphan), .err_missing(err_missing)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    case (u)
      0:       return LAT_P;
      1:       return LAT_LS;
      default: return LAT_BR;
    endcase
  endfunction

  function automatic int unit_of(input logic [1:0] iu);
    return (iu == 2'd3) ? 0 : int'(iu);
  endfunction

  // Reference model: list of issued writers with their issue cycle.
  typedef struct {
    int                icyc;
    int                addr;
    int                unit;
    logic [DATA_W-1:0] data;
    bit                dropped;
  } rec_t;

  rec_t q[$];
  int   cur = 0;
  bit   m_orphan = 1'b0;
  bit   m_missing = 1'b0;
  bit   m_hit_u [3];

  // Model update at the end of every cycle.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_orphan  = 1'b0;
      m_missing = 1'b0;
    end else begin
      if (issue_valid && issue_reg_write)
        q.push_back('{cur, int'(issue_rt_addr), unit_of(issue_unit), '0, 1'b0});
      m_hit_u = '{1'b0, 1'b0, 1'b0};
      foreach (q[j]) begin
        if (!q[j].dropped && (cur - q[j].icyc == lat_of(q[j].unit) - 1)) begin
          m_hit_u[q[j].unit] = 1'b1;
          if (unit_valid[q[j].unit])
            q[j].data = unit_data[q[j].unit*DATA_W +: DATA_W];
          else begin
            q[j].dropped = 1'b1;
            m_missing    = 1'b1;
          end
        end
      end
      for (int u = 0; u < 3; u++)
        if (unit_valid[u] && !m_hit_u[u]) m_orphan = 1'b1;
      while (q.size() > 0 && (cur - q[0].icyc >= DEPTH)) void'(q.pop_front());
    end
    cur++;
  end

  // Compare process: every cycle, on the falling edge.
  logic [NUM_SRC-1:0]        e_stall, e_hit;
  logic [NUM_SRC*DATA_W-1:0] e_data;
  int                        b_age, b_unit, age;
  logic [DATA_W-1:0]         b_data;
  logic                      e_wbv;
  logic [ADDR_W-1:0]         e_wba;
  logic [DATA_W-1:0]         e_wbd;

  initial forever begin
    @(negedge clk);
    e_stall = '0;
    e_hit   = '0;
    e_data  = '0;
    if (reset) e_stall = '1;
    else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i]) begin
          b_age  = -1;
          b_unit = 0;
          b_data = '0;
          if (issue_valid && issue_reg_write && issue_rt_addr == src_addr[i*ADDR_W +: ADDR_W]) begin
            b_age  = 0;
            b_unit = unit_of(issue_unit);
          end else begin
            foreach (q[j]) begin
              age = cur - q[j].icyc;
              if (!q[j].dropped && q[j].addr == int'(src_addr[i*ADDR_W +: ADDR_W]) &&
                  age >= 1 && age <= DEPTH && (b_age < 0 || age < b_age)) begin
                b_age  = age;
                b_unit = q[j].unit;
                b_data = q[j].data;
              end
            end
          end
          if (b_age >= 0) begin
`ifdef FWD_MUX_EN
            if (b_age < lat_of(b_unit)) e_stall[i] = 1'b1;
            else begin
              e_hit[i] = 1'b1;
              e_data[i*DATA_W +: DATA_W] = b_data;
            end
`else
            e_stall[i] = 1'b1;
`endif
          end
        end
      end
    end
    check("model_src_stall", DATA_W'(src_stall), DATA_W'(e_stall));
    check("model_src_fwd_hit", DATA_W'(src_fwd_hit), DATA_W'(e_hit));
    for (int i = 0; i < NUM_SRC; i++)
      check($sformatf("model_fwd_data[%0d]", i), src_fwd_data[i*DATA_W +: DATA_W], e_data[i*DATA_W +: DATA_W]);
    if (!reset) begin
      e_wbv = 1'b0;
      e_wba = '0;
      e_wbd = '0;
      foreach (q[j]) begin
        if (!q[j].dropped && (cur - q[j].icyc == DEPTH)) begin
          e_wbv = 1'b1;
          e_wba = ADDR_W'(q[j].addr);
          e_wbd = q[j].data;
        end
      end
      check("model_wb_valid", DATA_W'(wb_valid), DATA_W'(e_wbv));
      check("model_wb_addr", DATA_W'(wb_addr), DATA_W'(e_wba));
      check("model_wb_data", wb_data, e_wbd);
      check("model_err_orphan", DATA_W'(err_orphan), DATA_W'(m_orphan));
      check("model_err_missing", DATA_W'(err_missing), DATA_W'(m_missing));
    end
  end

  // Stimulus helpers: a new cycle starts 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    issue_valid     = 1'b0;
    issue_reg_write = 1'b0;
    issue_unit      = '0;
    issue_rt_addr   = '0;
    unit_valid      = '0;
    unit_data       = '0;
    src_valid       = '0;
    src_addr        = '0;
  endtask

  task automatic issue(input logic [1:0] u, input logic [ADDR_W-1:0] a);
    issue_valid     = 1'b1;
    issue_reg_write = 1'b1;
    issue_unit      = u;
    issue_rt_addr   = a;
  endtask

  task automatic result(input int u, input logic [DATA_W-1:0] d);
    unit_valid[u]                  = 1'b1;
    unit_data[u*DATA_W +: DATA_W] = d;
  endtask

  task automatic rd(input int lane, input logic [ADDR_W-1:0] a);
    src_valid[lane]                  = 1'b1;
    src_addr[lane*ADDR_W +: ADDR_W] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    // Reset, with an operand read that must still report stall.
    next_cycle(); reset = 1'b1; rd(4, 7'd1);
    @(negedge clk); check("rst_stall_all", DATA_W'(src_stall), DATA_W'(6'h3F));
    check("rst_hit_zero", DATA_W'(src_fwd_hit), '0);
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("post_rst_wb_valid", DATA_W'(wb_valid), '0);
    check("post_rst_wb_addr", DATA_W'(wb_addr), '0);
    check("post_rst_wb_data", wb_data, '0);
    check("post_rst_err_orphan", DATA_W'(err_orphan), '0);
    check("post_rst_err_missing", DATA_W'(err_missing), '0);

    // Permute forwarding (r5, data 0xA5 in cycle 3); non-writing issue in cycle 1.
    next_cycle(); issue(2'd0, 7'd5); rd(0, 7'd5);
    @(negedge clk); check("p_c0_stall", DATA_W'(src_stall[0]), 1);
    next_cycle(); rd(0, 7'd5);
    issue_valid = 1'b1; issue_reg_write = 1'b0; issue_unit = 2'd2; issue_rt_addr = 7'd5;
    next_cycle(); rd(0, 7'd5);
    next_cycle(); rd(0, 7'd5); result(0, 128'hA5);
    @(negedge clk); check("p_c3_stall", DATA_W'(src_stall[0]), 1);
    next_cycle(); rd(0, 7'd5);
    @(negedge clk);
`ifdef FWD_MUX_EN
    check("p_c4_hit", DATA_W'(src_fwd_hit[0]), 1);
    check("p_c4_data", src_fwd_data[0 +: DATA_W], 128'hA5);
    check("p_c4_stall", DATA_W'(src_stall[0]), 0);
`else
    check("p_c4_stall", DATA_W'(src_stall[0]), 1);
    check("p_c4_hit", DATA_W'(src_fwd_hit[0]), 0);
`endif
    next_cycle(); rd(0, 7'd5);
    next_cycle(); rd(0, 7'd5);
    next_cycle(); rd(0, 7'd5);
    @(negedge clk);
    check("p_c7_wb_valid", DATA_W'(wb_valid), 1);
    check("p_c7_wb_addr", DATA_W'(wb_addr), 5);
    check("p_c7_wb_data", wb_data, 128'hA5);
`ifdef FWD_MUX_EN
    check("p_c7_hit", DATA_W'(src_fwd_hit[0]), 1);
`else
    check("p_c7_stall", DATA_W'(src_stall[0]), 1);
`endif
    next_cycle(); rd(0, 7'd5);
    @(negedge clk);
    check("p_c8_stall", DATA_W'(src_stall[0]), 0);
    check("p_c8_hit", DATA_W'(src_fwd_hit[0]), 0);
    check("p_c8_wb_valid", DATA_W'(wb_valid), 0);

    // Youngest wins: LS r9 in cycle 0, BR r9 in cycle 1.
    next_cycle(); issue(2'd1, 7'd9);
    next_cycle(); issue(2'd2, 7'd9); result(2, 128'h11);
    next_cycle(); rd(1, 7'd9);
    @(negedge clk);
`ifdef FWD_MUX_EN
    check("yw_c2_hit", DATA_W'(src_fwd_hit[1]), 1);
    check("yw_c2_data", src_fwd_data[DATA_W +: DATA_W], 128'h11);
`else
    check("yw_c2_stall", DATA_W'(src_stall[1]), 1);
`endif
    next_cycle();
    next_cycle();
    next_cycle(); result(1, 128'h22);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("yw_c7_wb_addr", DATA_W'(wb_addr), 9);
    check("yw_c7_wb_data", wb_data, 128'h22);
    next_cycle();
    @(negedge clk);
    check("yw_c8_wb_valid", DATA_W'(wb_valid), 1);
    check("yw_c8_wb_data", wb_data, 128'h11);

    // Young pending masks old forwardable: BR r3 then LS r3 in cycle 2.
    next_cycle(); issue(2'd2, 7'd3); result(2, 128'h33);
    next_cycle(); rd(2, 7'd3);
    @(negedge clk);
`ifdef FWD_MUX_EN
    check("mask_c1_data", src_fwd_data[2*DATA_W +: DATA_W], 128'h33);
`else
    check("mask_c1_stall", DATA_W'(src_stall[2]), 1);
`endif
    next_cycle(); issue(2'd1, 7'd3); rd(2, 7'd3);
    @(negedge clk); check("mask_c2_same_cycle_stall", DATA_W'(src_stall[2]), 1);
    next_cycle(); rd(2, 7'd3);
    @(negedge clk);
    check("mask_c3_stall", DATA_W'(src_stall[2]), 1);
    check("mask_c3_hit", DATA_W'(src_fwd_hit[2]), 0);
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle(); result(1, 128'h44);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("mask_c9_wb_data", wb_data, 128'h44);
    next_cycle();
    check("pre_err_orphan", DATA_W'(err_orphan), 0);
    check("pre_err_missing", DATA_W'(err_missing), 0);

    // Errors: orphan LS result, then a P issue (code 3) whose result never comes.
    next_cycle(); result(1, 128'h55);
    next_cycle(); issue(2'd3, 7'd7);
    @(negedge clk); check("err_orphan_set", DATA_W'(err_orphan), 1);
    next_cycle(); rd(3, 7'd7);
    @(negedge clk); check("err_pending_stall", DATA_W'(src_stall[3]), 1);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("err_missing_set", DATA_W'(err_missing), 1);
    check("err_orphan_sticky", DATA_W'(err_orphan), 1);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk); check("err_no_wb", DATA_W'(wb_valid), 0);

    // Reset mid-flight: P r6 in cycle 0, reset in cycle 3.
    next_cycle(); issue(2'd0, 7'd6);
    next_cycle();
    next_cycle(); rd(0, 7'd6);
    @(negedge clk); check("rmf_c2_stall", DATA_W'(src_stall[0]), 1);
    next_cycle(); reset = 1'b1; rd(0, 7'd6);
    @(negedge clk);
    check("rmf_rst_stall_all", DATA_W'(src_stall), DATA_W'(6'h3F));
    check("rmf_rst_hit", DATA_W'(src_fwd_hit), '0);
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("rmf_err_orphan_clr", DATA_W'(err_orphan), 0);
    check("rmf_err_missing_clr", DATA_W'(err_missing), 0);
    check("rmf_wb_valid_c4", DATA_W'(wb_valid), 0);
    next_cycle(); rd(0, 7'd6);
    @(negedge clk); check("rmf_c5_no_stall", DATA_W'(src_stall[0]), 0);
    next_cycle();
    next_cycle();
    @(negedge clk); check("rmf_c7_no_wb", DATA_W'(wb_valid), 0);
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/odd_fwd_scoreboard.md
# odd_fwd_scoreboard

Parametrised result-staging, forwarding and RAW-hazard scoreboard for the odd pipe. Sits between the odd-pipe execution units (permute, local store, branch) and the register file. It tracks every issued register-writing instruction by age and captures each unit's result into a staging shift register at the stage equal to that unit's latency. Per source operand, it returns either a forwarded value, a stall, or a miss (read the RF). It replaces fixed-depth staging and whole-pipe stall logic with latency-aware, per-operand forwarding.

## Interface
- DEPTH, 7: staging stages 1..DEPTH-1 plus the write-back register (stage DEPTH).
- DATA_W, 128: result width.
- ADDR_W, 7: register address width.
- NUM_SRC, 6: source operands queried per cycle (odd and even pipes combined).
- LAT_P, 4: permute latency, in stages.
- LAT_LS, 6: local-store latency.
- LAT_BR, 1: branch latency.
- All latencies are legal only in the range 1..DEPTH-1.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  instruction issued this cycle.
- issue_unit  in  2  0 = P, 1 = LS, 2 = BR, 3 = P.
- issue_rt_addr  in  ADDR_W  destination register.
- issue_reg_write  in  1  instruction writes the RF.
- unit_valid  in  3  per-unit result strobe; bit 0 = P, bit 1 = LS, bit 2 = BR.
- unit_data  in  3×DATA_W  per-unit result.
- src_addr  in  NUM_SRC×ADDR_W  operand addresses.
- src_valid  in  NUM_SRC  operand is actually read.
- src_stall  out  NUM_SRC  operand not yet available.
- src_fwd_hit  out  NUM_SRC  src_fwd_data is valid.
- src_fwd_data  out  NUM_SRC×DATA_W  forwarded value.
- wb_valid  out  1  RF write enable.
- wb_addr  out  ADDR_W  RF write address.
- wb_data  out  DATA_W  RF write data.
- err_orphan  out  1  sticky: unit result arrived with no matching tag.
- err_missing  out  1  sticky: tag reached its capture stage without a result.

## Operation
- **Tag pipe.** An issue with issue_valid & issue_reg_write creates a tag {addr, unit, lat}. The tag advances one age per cycle, from age 0 (the issue cycle) to age DEPTH. Non-writing issues create an empty slot.
- **Capture.** A unit-u result presented in cycle t+LAT_u-1 (issue in cycle t) is written into stage LAT_u together with the tag's address.
  - With one issue per cycle, no two tags share an age, so stage collisions are impossible by construction.
- **Error flags.**
  - unit_valid[u] with no tag of unit u at age LAT_u-1 sets err_orphan; the data is discarded.
  - A tag at age LAT_u-1 with unit_valid[u] low sets err_missing; the entry's write is dropped.
  - Both flags are sticky until reset.
- **Stage states.** Stages 1..DEPTH-1 shift each cycle unless overwritten by a capture. Stage DEPTH drives the wb_* outputs. A tag is pending at ages 0..lat-1 and forwardable at ages lat..DEPTH.
- **Per-operand lookup** (only when src_valid[i]):
  - Find the youngest tag (smallest age) whose addr matches src_addr[i].
  - If that tag is pending: src_stall = 1.
  - If it is forwardable: src_fwd_hit = 1 and src_fwd_data = that stage's data.
  - If no tag matches: all three outputs are 0 (read the RF).
  - An older forwardable match never masks a younger pending one.
- The age-0 comparison against the current issue is combinational. An operand matching same-cycle issue_rt_addr with issue_reg_write stalls.

## Timing
- Issue in cycle t: the result is forwardable in cycles t+LAT_u..t+DEPTH. wb_valid is high in cycle t+DEPTH; the RF holds the value from cycle t+DEPTH+1.
- src_* outputs are combinational from the inputs and the current state; there are no registered outputs on the lookup path.
- **During reset:** src_stall = all 1s; src_fwd_hit = 0; src_fwd_data = 0.
- **Cycle after reset:** all tags and stages are empty; wb_valid = 0, wb_addr = 0, wb_data = 0; both err flags are 0.
- **Reset mid-operation:** all in-flight tags and results are discarded; no write-back occurs for them.
- Concurrent captures into different stages in the same cycle are allowed. All stages update on the same edge.

## Configuration
- FWD_MUX_EN defined: behaviour as described above.
- FWD_MUX_EN undefined: the forwarding muxes are removed.
  - src_fwd_hit and src_fwd_data are tied to 0.
  - src_stall is raised for any matching tag at ages 0..DEPTH, i.e. stall until the write-back has completed.
  - Capture and write-back timing are unchanged.

## Test plan
- **Permute forwarding:** reset, then issue P writing r5 in cycle 0, with unit_data[0] = 0xA5 presented in cycle 3. A src_valid read of r5 gives src_stall = 1 in cycles 0..3, then fwd_hit = 1 with data 0xA5 in cycles 4..7. wb_valid = 1, wb_addr = 5 in cycle 7.
- **Youngest-wins priority:** issue LS to r9 in cycle 0, then BR to r9 in cycle 1 (BR data 0x11 in cycle 1). A read in cycle 2 forwards 0x11. Write-backs occur in cycle 7 (LS data) and cycle 8 (0x11).
- **Young pending masks old forwardable:** issue BR to r3 (forwardable from cycle 1), then LS to r3 in cycle 2. A read in cycle 3 gives src_stall = 1 despite the forwardable BR entry.
- **Unit result errors:** unit_valid[1] with no LS tag sets err_orphan = 1, and it stays set. Omitting a P result sets err_missing = 1, and no write-back occurs for that tag.
- **Reset mid-flight:** reset asserted in cycle 3 after a P issue in cycle 0. src_stall = all 1s during reset; no wb_valid afterwards.
- **FWD_MUX_EN undefined:** repeat the permute forwarding scenario. src_stall = 1 in cycles 0..7; fwd_hit stays 0.
